// File: rtl/sort4_ctrl.sv
// Four-element load/sort/unload engine built around one shared magnitude comparator.
// Define SORT4_DESCEND_EN to sort in descending order instead of ascending.
module sort4_ctrl #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic [2:0]   swap_cnt
);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

`ifdef SORT4_DESCEND_EN
  localparam logic [1:0] SWAP_CODE = 2'd0;
`else
  localparam logic [1:0] SWAP_CODE = 2'd2;
`endif

  state_t       state;
  logic [1:0]   idx;
  logic         pass_flag;
  logic [W-1:0] r [4];

  logic [W-1:0] cmp_a;
  logic [W-1:0] cmp_b;
  logic [1:0]   cmp_code;
  logic         do_swap;

  // Unsigned three-way compare: 2 = a>b, 1 = equal, 0 = a<b.
  function automatic logic [1:0] mag_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b)       return 2'd2;
    else if (a == b) return 2'd1;
    else             return 2'd0;
  endfunction

  always_comb begin
    cmp_a    = r[idx];
    cmp_b    = r[idx + 2'd1];
    cmp_code = mag_cmp(cmp_a, cmp_b);
    do_swap  = (state == SORT) && (cmp_code == SWAP_CODE);
  end

  // Handshake flags are gated by rst so they drop the moment reset asserts.
  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == OUT)  && !rst;
  assign busy      = (state == SORT) && !rst;
  assign out_data  = out_valid ? r[idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= 2'd0;
      pass_flag <= 1'b0;
      swap_cnt  <= 3'd0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            r[idx] <= in_data;
            if (idx == 2'd3) begin
              state     <= SORT;
              idx       <= 2'd0;
              pass_flag <= 1'b0;
              swap_cnt  <= 3'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            r[idx]        <= cmp_b;
            r[idx + 2'd1] <= cmp_a;
            swap_cnt      <= swap_cnt + 3'd1;
          end
          // End of a pass: another pass only if something moved during this one.
          if (idx == 2'd2) begin
            idx       <= 2'd0;
            pass_flag <= 1'b0;
            if (!(pass_flag || do_swap)) state <= OUT;
          end else begin
            idx       <= idx + 2'd1;
            pass_flag <= pass_flag || do_swap;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (idx == 2'd3) begin
              state <= LOAD;
              idx   <= 2'd0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: begin
          state <= LOAD;
          idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed bench for sort4_ctrl: load, sort latency, swap count, stalled unload, reset abort.
module tb_sort4_ctrl;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic [2:0]   swap_cnt;

  int vectors = 0;
  int fails   = 0;

  sort4_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    int v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      check("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[i][W-1:0];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Counts busy cycles (bounded); in_valid is driven with junk to show it is ignored.
  task automatic wait_sort(input int exp_cycles, input int exp_swaps);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 3'd6;
    while (busy && n < 40) begin
      check("sort_excl", int'(in_ready) + int'(out_valid), 0);
      n++;
      tick();
    end
    in_valid = 1'b0;
    check("sort_cycles", n, exp_cycles);
    check("swap_cnt", swap_cnt, exp_swaps);
    check("out_valid_after_sort", out_valid, 1);
  endtask

  task automatic drain4(input int a, input int b, input int c, input int d);
    int v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, v[i]);
      tick();
    end
    out_ready = 1'b0;
    check("drain_in_ready", in_ready, 1);
  endtask

  initial begin
    int pat [7];
    int exp_seq [4];
    int k;
    int xfers;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_swap_cnt", swap_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

`ifdef SORT4_DESCEND_EN
    load4(1, 6, 2, 5);
    wait_sort(9, 4);
    drain4(6, 5, 2, 1);
    check("descend_swap_hold", swap_cnt, 4);
`else
    // Already ordered: one clean pass.
    out_ready = 1'b1;
    load4(1, 2, 3, 4);
    out_ready = 1'b0;
    wait_sort(3, 0);
    drain4(1, 2, 3, 4);

    // Reverse order: worst case, four passes and six swaps.
    load4(7, 5, 3, 0);
    wait_sort(12, 6);
    drain4(0, 3, 5, 7);
    check("swap_hold_load", swap_cnt, 6);

    // Equal elements never swap.
    load4(4, 4, 2, 4);
    wait_sort(9, 2);
    drain4(2, 4, 4, 4);

    // Stalled unload with out_ready pattern 1,0,0,1,1,0,1.
    load4(7, 5, 3, 0);
    wait_sort(12, 6);
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    exp_seq[0] = 0; exp_seq[1] = 3; exp_seq[2] = 5; exp_seq[3] = 7;
    k = 0;
    xfers = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, exp_seq[k]);
      tick();
      if (pat[i] == 1) begin
        k++;
        xfers++;
      end
    end
    out_ready = 1'b0;
    check("stall_xfers", xfers, 4);
    check("stall_in_ready", in_ready, 1);
    check("stall_out_valid", out_valid, 0);
    check("swap_hold_out", swap_cnt, 6);

    // Reset during the fifth SORT cycle abandons the sort.
    load4(7, 5, 3, 0);
    check("abort_busy", busy, 1);
    for (int i = 0; i < 4; i++) tick();
    check("abort_still_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy_cleared", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_swap_cnt", swap_cnt, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_release_in_ready", in_ready, 1);
    load4(2, 1, 0, 3);
    wait_sort(9, 3);
    drain4(0, 1, 2, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
